// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - shared PC width, EXE correction encodings and next-PC source codes.
package fetch_pc_gen_pkg;

    localparam int PC_W = 11;

    localparam logic [1:0] CORR_NONE = 2'b00;
    localparam logic [1:0] CORR_CNI  = 2'b10;
    localparam logic [1:0] CORR_PBT  = 2'b11;

    typedef enum logic [2:0] {
        SRC_PEND,
        SRC_EXE,
        SRC_JUMP,
        SRC_RET,
        SRC_INT,
        SRC_PRED,
        SRC_SEQ
    } npc_src_e;

endpackage

// File: rtl/fetch_pc_gen_npc_mux.sv
// rtl/fetch_pc_gen_npc_mux.sv - next-PC priority mux; purely combinational, registers live in the top.
module npc_mux
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [PC_W-1:0] ISR_VECTOR = 11'h040
) (
    input  logic [PC_W-1:0] if_pc_i,
    input  logic            pend_valid_i,
    input  logic [PC_W-1:0] pend_pc_i,
    input  logic [1:0]      exe_correction_i,
    input  logic [PC_W-1:0] exe_cni_i,
    input  logic [PC_W-1:0] exe_pbt_i,
    input  logic            id_is_jump_i,
    input  logic            id_jump_in_bht_i,
    input  logic [PC_W-1:0] id_branchtarget_i,
    input  logic            id_is_ret_i,
    input  logic            isr_running_i,
    input  logic [PC_W-1:0] saved_pc_i,
    input  logic            int_req_i,
    input  logic            if_prediction_i,
    input  logic [PC_W-1:0] if_pbt_i,
    output logic [PC_W-1:0] next_pc_o,
    output logic [PC_W-1:0] seq_pc_o,
    output logic [PC_W-1:0] pc_inc_o,
    output npc_src_e        src_o,
    output logic            redirect_req_o,
    output logic [PC_W-1:0] redirect_pc_o
);

    logic exe_hit;
    logic jump_hit;

    assign pc_inc_o = if_pc_i + PC_W'(1);
    // Where fetch would go without any redirect; also the interrupt return address.
    assign seq_pc_o = if_prediction_i ? if_pbt_i : pc_inc_o;

    assign exe_hit  = (exe_correction_i == CORR_CNI) || (exe_correction_i == CORR_PBT);
    assign jump_hit = id_is_jump_i && !id_jump_in_bht_i;

    assign redirect_req_o = exe_hit || jump_hit;
    assign redirect_pc_o  = exe_hit ? ((exe_correction_i == CORR_PBT) ? exe_pbt_i : exe_cni_i)
                                    : id_branchtarget_i;

    always_comb begin
        src_o     = SRC_SEQ;
        next_pc_o = seq_pc_o;
        if (pend_valid_i) begin
            src_o     = SRC_PEND;
            next_pc_o = pend_pc_i;
        end else if (redirect_req_o) begin
            src_o     = exe_hit ? SRC_EXE : SRC_JUMP;
            next_pc_o = redirect_pc_o;
        end else if (id_is_ret_i && isr_running_i) begin
            src_o     = SRC_RET;
            next_pc_o = saved_pc_i;
        end else if (int_req_i && !isr_running_i) begin
            src_o     = SRC_INT;
            next_pc_o = ISR_VECTOR;
        end else if (if_prediction_i) begin
            src_o     = SRC_PRED;
            next_pc_o = if_pbt_i;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC register with stall-held redirects and ISR entry/return.
// Optional macro FETCH_MISPRED_CNT_EN adds a saturating EXE correction counter.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 11'h000,
    parameter logic [PC_W-1:0] ISR_VECTOR = 11'h040
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            en,
    input  logic            stall,
    input  logic            if_prediction,
    input  logic [PC_W-1:0] if_PBT,
    input  logic [1:0]      exe_correction,
    input  logic [PC_W-1:0] exe_CNI,
    input  logic [PC_W-1:0] exe_PBT,
    input  logic            id_is_jump,
    input  logic            id_jump_in_bht,
    input  logic [PC_W-1:0] id_branchtarget,
    input  logic            id_is_ret,
    input  logic            int_req,
    output logic [PC_W-1:0] if_PC,
    output logic            ISR_running,
    output logic            pc_redirect,
    output logic [15:0]     mispred_count
);

    logic [PC_W-1:0] pc_q;
    logic            isr_running_q;
    logic            pc_redirect_q;
    logic            pend_valid_q;
    logic [PC_W-1:0] pend_pc_q;
    logic [PC_W-1:0] saved_pc_q;

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] pc_inc;
    npc_src_e        src;
    logic            redirect_req;
    logic [PC_W-1:0] redirect_pc;

    npc_mux #(.ISR_VECTOR(ISR_VECTOR)) u_npc_mux (
        .if_pc_i          (pc_q),
        .pend_valid_i     (pend_valid_q),
        .pend_pc_i        (pend_pc_q),
        .exe_correction_i (exe_correction),
        .exe_cni_i        (exe_CNI),
        .exe_pbt_i        (exe_PBT),
        .id_is_jump_i     (id_is_jump),
        .id_jump_in_bht_i (id_jump_in_bht),
        .id_branchtarget_i(id_branchtarget),
        .id_is_ret_i      (id_is_ret),
        .isr_running_i    (isr_running_q),
        .saved_pc_i       (saved_pc_q),
        .int_req_i        (int_req),
        .if_prediction_i  (if_prediction),
        .if_pbt_i         (if_PBT),
        .next_pc_o        (pc_d),
        .seq_pc_o         (seq_pc),
        .pc_inc_o         (pc_inc),
        .src_o            (src),
        .redirect_req_o   (redirect_req),
        .redirect_pc_o    (redirect_pc)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            isr_running_q <= 1'b0;
            pc_redirect_q <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_pc_q     <= '0;
            saved_pc_q    <= '0;
        end else if (en) begin
            if (stall) begin
                pc_redirect_q <= 1'b0;
                // The oldest redirect seen during a stall is the one that must win.
                if (!pend_valid_q && redirect_req) begin
                    pend_valid_q <= 1'b1;
                    pend_pc_q    <= redirect_pc;
                end
            end else begin
                pc_q          <= pc_d;
                pc_redirect_q <= (pc_d != pc_inc);
                pend_valid_q  <= 1'b0;
                if (src == SRC_RET) begin
                    isr_running_q <= 1'b0;
                end
                if (src == SRC_INT) begin
                    isr_running_q <= 1'b1;
                    saved_pc_q    <= seq_pc;
                end
            end
        end
    end

`ifdef FETCH_MISPRED_CNT_EN
    logic [15:0] mispred_q;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            mispred_q <= '0;
        end else if (en && !stall && exe_correction[1] && (mispred_q != 16'hFFFF)) begin
            mispred_q <= mispred_q + 16'd1;
        end
    end

    assign mispred_count = mispred_q;
`else
    assign mispred_count = '0;
`endif

    assign if_PC       = pc_q;
    assign ISR_running = isr_running_q;
    assign pc_redirect = pc_redirect_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - scoreboard bench: directed scenarios then random stimulus against a reference model.
module tb_fetch_pc_gen;

    localparam logic [10:0] RST_PC = 11'h000;
    localparam logic [10:0] ISR_V  = 11'h040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en;
    logic        stall;
    logic        if_prediction;
    logic [10:0] if_PBT;
    logic [1:0]  exe_correction;
    logic [10:0] exe_CNI;
    logic [10:0] exe_PBT;
    logic        id_is_jump;
    logic        id_jump_in_bht;
    logic [10:0] id_branchtarget;
    logic        id_is_ret;
    logic        int_req;
    logic [10:0] if_PC;
    logic        ISR_running;
    logic        pc_redirect;
    logic [15:0] mispred_count;

    fetch_pc_gen #(.RESET_PC(RST_PC), .ISR_VECTOR(ISR_V)) dut (
        .CLK(clk), .rst(rst), .en(en), .stall(stall),
        .if_prediction(if_prediction), .if_PBT(if_PBT),
        .exe_correction(exe_correction), .exe_CNI(exe_CNI), .exe_PBT(exe_PBT),
        .id_is_jump(id_is_jump), .id_jump_in_bht(id_jump_in_bht),
        .id_branchtarget(id_branchtarget), .id_is_ret(id_is_ret),
        .int_req(int_req), .if_PC(if_PC), .ISR_running(ISR_running),
        .pc_redirect(pc_redirect), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] pc;
        logic        isr;
        logic        redir;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference state, kept as plain architectural quantities.
    logic [10:0] m_pc, m_pend_pc, m_saved;
    logic        m_isr, m_pend, m_redir;
    logic [15:0] m_cnt;

    function automatic void check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("if_PC", {5'd0, if_PC}, {5'd0, mon_e.pc});
            check("ISR_running", {15'd0, ISR_running}, {15'd0, mon_e.isr});
            check("pc_redirect", {15'd0, pc_redirect}, {15'd0, mon_e.redir});
            check("mispred_count", mispred_count, mon_e.cnt);
        end
    end

    task automatic idle();
        en = 1'b1; stall = 1'b0; if_prediction = 1'b0; if_PBT = '0;
        exe_correction = 2'b00; exe_CNI = '0; exe_PBT = '0;
        id_is_jump = 1'b0; id_jump_in_bht = 1'b0; id_branchtarget = '0;
        id_is_ret = 1'b0; int_req = 1'b0;
    endtask

    // Applies the current inputs for one edge and pushes what the edge must produce.
    task automatic cyc();
        logic [10:0] seq, npc, inc;
        logic        taken;
        exp_t        e;
        if (rst) begin
            m_pc = RST_PC; m_isr = 0; m_redir = 0; m_pend = 0; m_pend_pc = 0; m_saved = 0; m_cnt = 0;
        end else if (en && stall) begin
            m_redir = 0;
            if (!m_pend && (exe_correction[1] || (id_is_jump && !id_jump_in_bht))) begin
                m_pend = 1;
                if (exe_correction == 2'b11) m_pend_pc = exe_PBT;
                else if (exe_correction == 2'b10) m_pend_pc = exe_CNI;
                else m_pend_pc = id_branchtarget;
            end
        end else if (en) begin
            inc   = m_pc + 11'd1;
            seq   = if_prediction ? if_PBT : inc;
            taken = 1;
            if (m_pend) npc = m_pend_pc;
            else if (exe_correction == 2'b11) npc = exe_PBT;
            else if (exe_correction == 2'b10) npc = exe_CNI;
            else if (id_is_jump && !id_jump_in_bht) npc = id_branchtarget;
            else if (id_is_ret && m_isr) begin npc = m_saved; m_isr = 0; end
            else taken = 0;
            if (!taken) begin
                if (int_req && !m_isr) begin npc = ISR_V; m_saved = seq; m_isr = 1; end
                else npc = seq;
            end
            m_pend  = 0;
            m_redir = (npc != inc);
            m_pc    = npc;
            if (exe_correction[1] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        e.pc = m_pc; e.isr = m_isr; e.redir = m_redir;
`ifdef FETCH_MISPRED_CNT_EN
        e.cnt = m_cnt;
`else
        e.cnt = 16'd0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic expect_pc(input string name, input logic [10:0] pc, input logic isr, input logic redir);
        check({name, ".pc"}, {5'd0, if_PC}, {5'd0, pc});
        check({name, ".isr"}, {15'd0, ISR_running}, {15'd0, isr});
        check({name, ".redir"}, {15'd0, pc_redirect}, {15'd0, redir});
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        expect_pc("reset", 11'h000, 1'b0, 1'b0);
        check("reset.cnt", mispred_count, 16'd0);
        rst = 1'b0;
        cyc(); expect_pc("seq1", 11'h001, 1'b0, 1'b0);
        cyc(); expect_pc("seq2", 11'h002, 1'b0, 1'b0);
        exe_correction = 2'b10; exe_CNI = 11'h7FF;
        cyc(); expect_pc("to7ff", 11'h7FF, 1'b0, 1'b1);
        idle();
        cyc(); expect_pc("wrap", 11'h000, 1'b0, 1'b0);

        if_prediction = 1'b1; if_PBT = 11'h120; exe_correction = 2'b11; exe_PBT = 11'h050;
        cyc(); expect_pc("exe_over_pred", 11'h050, 1'b0, 1'b1);
        idle();
        cyc();
        stall = 1'b1; exe_correction = 2'b10; exe_CNI = 11'h033;
        cyc(); expect_pc("stall1", 11'h051, 1'b0, 1'b0);
        exe_correction = 2'b00;
        cyc(); cyc(); expect_pc("stall3", 11'h051, 1'b0, 1'b0);
        stall = 1'b0;
        cyc(); expect_pc("pend_load", 11'h033, 1'b0, 1'b1);

        exe_correction = 2'b10; exe_CNI = 11'h00F;
        cyc(); idle(); cyc(); expect_pc("at010", 11'h010, 1'b0, 1'b0);
        int_req = 1'b1;
        cyc(); expect_pc("int_entry", ISR_V, 1'b1, 1'b1);
        int_req = 1'b0;
        cyc(); expect_pc("in_isr", 11'h041, 1'b1, 1'b0);
        id_is_ret = 1'b1;
        cyc(); expect_pc("int_ret", 11'h011, 1'b0, 1'b1);
        idle();

        int_req = 1'b1; id_is_jump = 1'b1; id_jump_in_bht = 1'b0; id_branchtarget = 11'h200;
        cyc(); expect_pc("jump_over_int", 11'h200, 1'b0, 1'b1);
        id_is_jump = 1'b0;
        cyc(); expect_pc("late_int", ISR_V, 1'b1, 1'b1);
        idle(); id_is_ret = 1'b1;
        cyc(); expect_pc("late_ret", 11'h201, 1'b0, 1'b1);
        idle();

        rst = 1'b1; cyc(); rst = 1'b0;
        exe_correction = 2'b10; exe_CNI = 11'h100;
        cyc();
        stall = 1'b1; exe_correction = 2'b11; exe_PBT = 11'h300;
        cyc();
        stall = 1'b0; exe_correction = 2'b10; exe_CNI = 11'h400;
        cyc(); expect_pc("pend_beats_exe", 11'h300, 1'b0, 1'b1);
`ifdef FETCH_MISPRED_CNT_EN
        check("cnt_after3", mispred_count, 16'd2);
`else
        check("cnt_after3", mispred_count, 16'd0);
`endif
        idle(); rst = 1'b1;
        #1;
        check("async_rst.pc", {5'd0, if_PC}, {5'd0, RST_PC});
        check("async_rst.cnt", mispred_count, 16'd0);
        cyc(); rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 99) < 2);
            en             = ($urandom_range(0, 9) != 0);
            stall          = ($urandom_range(0, 3) == 0);
            if_prediction  = ($urandom_range(0, 2) == 0);
            if_PBT         = 11'($urandom);
            exe_correction = ($urandom_range(0, 9) < 7) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            exe_CNI        = 11'($urandom);
            exe_PBT        = 11'($urandom);
            id_is_jump     = ($urandom_range(0, 6) == 0);
            id_jump_in_bht = 1'($urandom);
            id_branchtarget = 11'($urandom);
            id_is_ret      = ($urandom_range(0, 7) == 0);
            int_req        = ($urandom_range(0, 7) == 0);
            cyc();
        end
        rst = 1'b0; idle();
        cyc(); cyc();
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 11'h000: first fetch word address after reset.
REQ-002 SHALL have parameter ISR_VECTOR, default 11'h040: interrupt service routine entry word address.
REQ-003 SHALL have ports:
- CLK  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; low freezes all state.
- stall  in  1  fetch hold; PC does not advance.
- if_prediction  in  1  branch predictor taken bit for current if_PC.
- if_PBT  in  11  predicted branch target for if_PC.
- exe_correction  in  2  EXE correction: 0x = none, 10 = exe_CNI, 11 = exe_PBT.
- exe_CNI  in  11  correct next instruction address.
- exe_PBT  in  11  correct taken target.
- id_is_jump  in  1  ID holds a jump.
- id_jump_in_bht  in  1  ID jump already in the predictor table.
- id_branchtarget  in  11  ID-computed jump target.
- id_is_ret  in  1  ID holds an interrupt return.
- int_req  in  1  level interrupt request.
- if_PC  out  11  current fetch word address.
- ISR_running  out  1  high while in ISR; predictor tag MSB.
- pc_redirect  out  1  one-cycle pulse: last PC update was non-sequential.
- mispred_count  out  16  EXE correction count (macro-dependent).

Function
REQ-004 next_pc SHALL be the first true source, in priority order:
- pending redirect (REQ-006)
- exe_correction=10 -> exe_CNI; exe_correction=11 -> exe_PBT
- id_is_jump && !id_jump_in_bht -> id_branchtarget
- id_is_ret && ISR_running -> saved_pc
- interrupt entry (REQ-007) -> ISR_VECTOR
- if_prediction -> if_PBT
- otherwise if_PC + 1, modulo 2^11 (0x7FF wraps to 0x000).
REQ-005 When en && !stall, if_PC SHALL load next_pc on each edge. Latency is one cycle from select inputs to if_PC.
REQ-006 Stall handling:
- If stall && en and exe_correction[1]=1 or an ID jump redirect is present, the unit SHALL capture the target in pend_pc and set pend_valid.
- Only the first capture is kept; later redirects during the same stall SHALL NOT overwrite it.
- pend_valid SHALL clear on the first non-stalled enabled edge, which loads pend_pc.
REQ-007 Interrupt entry SHALL occur when all of the following hold:
- int_req && !ISR_running && en && !stall
- no EXE, ID-jump, pending or return redirect that cycle.
On entry: saved_pc <= the address that would otherwise have been next_pc; ISR_running <= 1.
REQ-008 On an interrupt return, ISR_running SHALL clear on the edge that loads saved_pc. id_is_ret while !ISR_running SHALL be ignored.
REQ-009 pc_redirect SHALL be 1 for the cycle after any edge where next_pc is not if_PC + 1; otherwise 0.
REQ-010 With en=0, all registers SHALL hold, including pend_valid and saved_pc.
REQ-011 An EXE correction arriving in the same cycle as a pending redirect SHALL be dropped; the pending redirect is older and wins.

Reset
REQ-012 On rst assertion, the unit SHALL asynchronously set:
- if_PC=RESET_PC
- ISR_running=0, pc_redirect=0
- pend_valid=0, pend_pc=0
- saved_pc=0
- mispred_count=0.
REQ-013 Reset asserted mid-stall or mid-ISR SHALL discard the pending redirect and saved_pc. Fetch restarts at RESET_PC on the first edge after deassertion.

Configuration
REQ-014 Macro FETCH_MISPRED_CNT_EN controls the misprediction counter:
- Defined: mispred_count increments by 1, saturating at 16'hFFFF, on each enabled non-stalled edge with exe_correction[1]=1.
- Undefined: mispred_count SHALL be tied to 0 and no counter flops SHALL be present.

Structure
REQ-015 A shared package SHALL hold the 11-bit PC width constant and the exe_correction encodings (CORR_NONE, CORR_CNI, CORR_PBT).
REQ-016 The next-PC priority mux SHALL be a sub-module, npc_mux. fetch_pc_gen keeps all registers.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset, RESET_PC=0x000, no predictions -> if_PC 0x000,0x001,0x002 on successive edges; 0x7FF -> 0x000 wrap.
- if_prediction=1, if_PBT=0x120, exe_correction=11, exe_PBT=0x050 same cycle -> if_PC=0x050, pc_redirect=1 next cycle.
- stall=1 for 3 cycles, exe_correction=10 with exe_CNI=0x033 in stall cycle 1 -> if_PC held, then 0x033 on the first unstalled edge.
- int_req=1 at if_PC=0x010, no redirect -> if_PC=ISR_VECTOR, ISR_running=1; later id_is_ret=1 -> if_PC=0x011, ISR_running=0.
- int_req=1 same cycle as id_is_jump=1, id_jump_in_bht=0, target 0x200 -> if_PC=0x200, no interrupt entry; entry on a later cycle.
- Macro defined, 3 corrections with one during stall -> mispred_count=2; rst mid-count -> 0.
